// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: mode encodings, threshold FSM states, default widths.
package counter_pkg;

  localparam int UPPER_W_DEFAULT = 12;

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_BELOW = 1'b0,
    ST_ABOVE = 1'b1
  } thr_state_t;

endpackage

// File: rtl/counter_extender_snap_buffer.sv
// Single-entry valid/ready snapshot register; capture lands on the next edge.
// A capture is accepted when empty or when the held entry is acked that same cycle, else flagged as a drop.
module snap_buffer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         capture,
  input  logic [W-1:0] cap_data,
  input  logic         snap_ready,
  output logic         snap_valid,
  output logic [W-1:0] snap_data,
  output logic         drop_evt
);

  logic accept;

  assign accept   = capture && (!snap_valid || snap_ready);
  assign drop_evt = capture && snap_valid && !snap_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_valid <= 1'b0;
      snap_data  <= '0;
    end else if (accept) begin
      snap_valid <= 1'b1;
      snap_data  <= cap_data;
    end else if (snap_valid && snap_ready) begin
      snap_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_extender.sv
// Extends the 4-bit counter with an upper register, sticky wrap flags and a threshold-crossing snapshot.
// Upper/flags update one edge after the cause; snapshot is presented one edge after a crossing via valid/ready.
module counter_extender
  import counter_pkg::*;
#(
  parameter int UPPER_W = UPPER_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [3:0]         Q,
  input  logic               rco,
  input  logic               load,
  input  logic [UPPER_W+3:0] thr,
  input  logic               clr_flags,
  output logic [UPPER_W+3:0] ext_value,
  output logic               ovf,
  output logic               unf,
  output logic               snap_valid,
  output logic [UPPER_W+3:0] snap_data,
  input  logic               snap_ready,
  output logic               drop
);

  localparam int EXT_W = UPPER_W + 4;

  logic [UPPER_W-1:0] upper;
  logic [UPPER_W-1:0] upper_nxt;
  logic               set_ovf;
  logic               set_unf;
  logic               at_or_above;
  logic               crossing;
  logic               drop_evt;
  thr_state_t         state;

  assign ext_value   = {upper, Q};
  assign at_or_above = (ext_value >= thr);
  assign crossing    = (state == ST_BELOW) && at_or_above;

  // Load beats a step; a load-mode rco without load leaves upper alone.
  always_comb begin
    upper_nxt = upper;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (load) begin
      upper_nxt = '0;
    end else if (enable && rco) begin
      case (mode)
        MODE_DOWN: begin
          upper_nxt = upper - UPPER_W'(1);
          set_unf   = (upper == '0);
        end
        MODE_LOAD: upper_nxt = upper;
        default: begin
          upper_nxt = upper + UPPER_W'(1);
          set_ovf   = &upper;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upper <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      drop  <= 1'b0;
      state <= ST_BELOW;
    end else begin
      upper <= upper_nxt;
      ovf   <= set_ovf  || (ovf  && !clr_flags);
      unf   <= set_unf  || (unf  && !clr_flags);
      drop  <= drop_evt || (drop && !clr_flags);
      case (state)
        ST_BELOW: if (at_or_above)  state <= ST_ABOVE;
        ST_ABOVE: if (!at_or_above) state <= ST_BELOW;
        default:                    state <= ST_BELOW;
      endcase
    end
  end

  snap_buffer #(
    .W(EXT_W)
  ) u_snap (
    .clk        (clk),
    .reset      (reset),
    .capture    (crossing),
    .cap_data   (ext_value),
    .snap_ready (snap_ready),
    .snap_valid (snap_valid),
    .snap_data  (snap_data),
    .drop_evt   (drop_evt)
  );

endmodule
